uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 106 ++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a power-of-two receive FIFO.
//   clk, reset     : single clock, synchronous active-high reset
//   rx             : asynchronous serial line, idle high, LSB first
//   div            : clk cycles per bit (clamped to a minimum of 4)
//   dout/valid     : FIFO head byte (0 when empty) and !empty
//   ready          : consumer accept, pops when valid && ready
//   empty/full     : FIFO occupancy flags
//   framing_err    : one-cycle pulse on a low stop bit
//   overrun        : one-cycle pulse when a good byte is dropped on a full FIFO
module uart_rx #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic [15:0] div,
  output logic [7:0]  dout,
  output logic        valid,
  input  logic        ready,
  output logic        empty,
  output logic        full,
  output logic        framing_err,
  output logic        overrun
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  state_t        state_q;
  logic [1:0]    sync_q;
  logic [15:0]   d_q, cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          ferr_q, ovr_q;
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] count_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic          rs, tick, push_d, pop_d, wr_d, drop_d;
  logic [15:0]   dclamp;
  assign rs     = sync_q[1];
  assign tick   = cnt_q == 16'd0;
  assign dclamp = (div < 16'd4) ? 16'd4 : div;
  assign empty  = count_q == '0;
  assign full   = count_q == CW'(FIFO_DEPTH);
  assign valid  = !empty;
  assign dout   = empty ? 8'h00 : mem_q[rp_q];
  assign framing_err = ferr_q;
  assign overrun     = ovr_q;
  // A good stop bit pushes; a full FIFO only accepts it if the head leaves this cycle.
  assign push_d = state_q == STOP && tick && rs;
  assign pop_d  = valid && ready;
  assign wr_d   = push_d && (!full || pop_d);
  assign drop_d = push_d && full && !pop_d;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sync_q  <= 2'b11;
      d_q     <= 16'd4;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      sync_q  <= {sync_q[0], rx};
      ferr_q  <= 1'b0;
      ovr_q   <= drop_d;
      wp_q    <= wp_q + AW'(wr_d);
      rp_q    <= rp_q + AW'(pop_d);
      count_q <= count_q + CW'(wr_d) - CW'(pop_d);
      case (state_q)
        // Counter is loaded so the start sample lands floor(d/2) cycles after the falling edge.
        IDLE: if (!rs) begin
          d_q     <= dclamp;
          cnt_q   <= {1'b0, dclamp[15:1]} - 16'd1;
          state_q <= START;
        end
        START: if (!tick) cnt_q <= cnt_q - 16'd1;
        else if (!rs) begin
          cnt_q   <= d_q - 16'd1;
          bit_q   <= '0;
          state_q <= DATA;
        end else state_q <= IDLE;
        DATA: if (!tick) cnt_q <= cnt_q - 16'd1;
        else begin
          shift_q <= {rs, shift_q[7:1]};
          cnt_q   <= d_q - 16'd1;
          bit_q   <= bit_q + 3'd1;
          state_q <= (bit_q == 3'd7) ? STOP : DATA;
        end
        // Leaving mid-stop-bit lets a back-to-back start edge be caught.
        STOP: if (!tick) cnt_q <= cnt_q - 16'd1;
        else if (rs) state_q <= IDLE;
        else begin
          ferr_q  <= 1'b1;
          state_q <= BREAK;
        end
        BREAK: if (rs) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) if (wr_d) mem_q[wp_q] <= shift_q;
endmodule
